// File: rtl/csi2_packet_builder.sv
// CSI-2 packet builder: FS, one long packet per line (hdr+ECC, payload, CRC-16), FE.
// Ports: cfg_* latched at frame start, s_axis pixel bytes in, m_axis packet bytes out, err_len, frame_cnt.
module csi2_packet_builder #(
  parameter int LINES_PER_FRAME = 4,
  parameter int WC_W            = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      cfg_vc,
  input  logic [5:0]      cfg_dt,
  input  logic [WC_W-1:0] cfg_wc,
  input  logic [7:0]      s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic            s_axis_tlast,
  input  logic            s_axis_tuser,
  output logic [7:0]      m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic            m_axis_tuser,
  output logic            err_len,
  output logic [15:0]     frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, FS_HDR, LP_HDR, PAYLOAD, CRC, FE_HDR
  } state_t;

  localparam logic [15:0] LAST_LINE = 16'(LINES_PER_FRAME - 1);

  state_t          state;
  logic [WC_W-1:0] cnt;
  logic [WC_W-1:0] wc_q;
  logic [1:0]      vc_q;
  logic [5:0]      dt_q;
  logic [15:0]     line_cnt;
  logic [15:0]     crc;

  logic        ld;
  logic        hdr_last;
  logic        pay_last;
  logic        first_px;
  logic [15:0] fn_next;
  logic [15:0] wc16;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]
         ^ d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]
         ^ d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]
         ^ d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]
         ^ d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]
         ^ d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]
         ^ d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [7:0] hdr_byte(
    input logic [7:0]  di,
    input logic [15:0] wc,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = di;
      2'd1:    b = wc[7:0];
      2'd2:    b = wc[15:8];
      default: b = {2'b00, ecc6({wc, di})};
    endcase
    return b;
  endfunction

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    end
    return r;
  endfunction

  assign ld            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == PAYLOAD) && ld;
  assign hdr_last      = (cnt[1:0] == 2'd3);
  assign pay_last      = (cnt == wc_q - WC_W'(1));
  // the tuser byte that opened the frame is legitimately the first pixel
  assign first_px     = (line_cnt == 16'd0) && (cnt == '0);
  assign fn_next       = (frame_cnt == 16'hFFFF) ? 16'd1
                                                 : frame_cnt + 16'd1;
  assign wc16          = 16'(wc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      wc_q          <= '0;
      vc_q          <= '0;
      dt_q          <= '0;
      line_cnt      <= '0;
      crc           <= 16'hFFFF;
      frame_cnt     <= '0;
      err_len       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (ld) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s_axis_tvalid && s_axis_tuser) begin
            vc_q          <= cfg_vc;
            dt_q          <= cfg_dt;
            wc_q          <= cfg_wc;
            frame_cnt     <= fn_next;
            line_cnt      <= '0;
            cnt           <= WC_W'(1);
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= 1'b1;
            m_axis_tdata  <= {cfg_vc, 6'h00};
            state         <= FS_HDR;
          end
        end
        FS_HDR: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= hdr_last;
          m_axis_tdata  <= hdr_byte({vc_q, 6'h00}, frame_cnt, cnt[1:0]);
          cnt           <= cnt + WC_W'(1);
          if (hdr_last) begin
            cnt   <= '0;
            state <= LP_HDR;
          end
        end
        LP_HDR: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tuser  <= (cnt[1:0] == 2'd0);
          m_axis_tdata  <= hdr_byte({vc_q, dt_q}, wc16, cnt[1:0]);
          cnt           <= cnt + WC_W'(1);
          if (hdr_last) begin
            cnt   <= '0;
            crc   <= 16'hFFFF;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (s_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            crc           <= crc_byte(crc, s_axis_tdata);
            cnt           <= cnt + WC_W'(1);
            if ((s_axis_tlast != pay_last) ||
                (s_axis_tuser && !first_px))
              err_len <= 1'b1;
            if (pay_last) begin
              cnt   <= '0;
              state <= CRC;
            end
          end
        end
        CRC: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= cnt[0];
          m_axis_tdata  <= cnt[0] ? crc[15:8] : crc[7:0];
          cnt           <= cnt + WC_W'(1);
          if (cnt[0]) begin
            cnt      <= '0;
            line_cnt <= line_cnt + 16'd1;
            state    <= (line_cnt == LAST_LINE) ? FE_HDR : LP_HDR;
          end
        end
        FE_HDR: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tuser  <= (cnt[1:0] == 2'd0);
          m_axis_tlast  <= hdr_last;
          m_axis_tdata  <= hdr_byte({vc_q, 6'h01}, frame_cnt, cnt[1:0]);
          cnt           <= cnt + WC_W'(1);
          if (hdr_last) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_packet_builder.sv
// Self-checking bench for csi2_packet_builder.
// Random payload/handshakes against a byte-level packet model.
module tb_csi2_packet_builder;

  localparam int LPF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_vc = '0;
  logic [5:0]  cfg_dt = '0;
  logic [15:0] cfg_wc = 16'd1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        m_tuser;
  logic        err_len;
  logic [15:0] frame_cnt;

  csi2_packet_builder #(
    .LINES_PER_FRAME(LPF),
    .WC_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_vc(cfg_vc),
    .cfg_dt(cfg_dt),
    .cfg_wc(cfg_wc),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser),
    .err_len(err_len),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // {user, last, data}
  logic [9:0] in_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         got_cyc[$];
  int         in_ptr = 0;
  int         in_duty = 100;
  int         out_duty = 100;
  int         cyc = 0;
  bit         took = 0;
  bit         stall = 0;
  logic [10:0] held;
  bit         tu_seen = 0;
  int         tu_cyc = 0;
  logic [15:0] fnum = 0;
  logic        exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ECC: parity of D[23:0] masked by each Hamming row
  function automatic logic [7:0] ecc_ref(input logic [23:0] d);
    logic [23:0] m[6];
    logic [7:0]  e;
    m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
    m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
    e = '0;
    for (int k = 0; k < 6; k++) e[k] = ^(d & m[k]);
    return e;
  endfunction

  // CRC computed in non-reflected form (0x1021) and bit-reversed
  function automatic logic [15:0] crc_ref(input logic [7:0] b[$]);
    logic [15:0] c, r;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[j])
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ b[j][i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return r;
  endfunction

  function automatic void put(input bit u, input bit l,
                              input logic [7:0] d);
    exp_q.push_back({u, l, d});
  endfunction

  function automatic void put_hdr(input logic [7:0] di,
                                  input logic [15:0] wc,
                                  input bit short_pkt);
    put(1, 0, di);
    put(0, 0, wc[7:0]);
    put(0, 0, wc[15:8]);
    put(0, short_pkt, ecc_ref({wc, di}));
  endfunction

  // mode: 0 random, 1 CRC vector, 2 early tlast, 3 stray tuser
  task automatic build(input int nfr, input int wc,
                       input logic [1:0] vc, input logic [5:0] dt,
                       input int mode);
    logic [7:0] vec[24];
    logic [7:0] pl[$];
    bit         u, l;
    vec = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3,
            8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75,
            8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF,
            8'h00, 8'h00, 8'h01};
    cfg_vc = vc;
    cfg_dt = dt;
    cfg_wc = 16'(wc);
    in_q.delete();
    in_ptr = 0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    tu_seen = 0;
    for (int f = 0; f < nfr; f++) begin
      fnum = (fnum == 16'hFFFF) ? 16'd1 : fnum + 16'd1;
      put_hdr({vc, 6'h00}, fnum, 1);
      for (int ln = 0; ln < LPF; ln++) begin
        put_hdr({vc, dt}, 16'(wc), 0);
        pl.delete();
        for (int i = 0; i < wc; i++) begin
          pl.push_back(mode == 1 ? vec[i % 24]
                                 : 8'($urandom_range(255)));
          u = (ln == 0 && i == 0) ||
              (mode == 3 && ln == 0 && i == 2);
          l = (i == wc - 1);
          if (mode == 2 && ln == 0) l = (i == 1);
          if (l != (i == wc - 1)) exp_err = 1;
          if (u && !(ln == 0 && i == 0)) exp_err = 1;
          in_q.push_back({u, l, pl[i]});
          put(0, 0, pl[i]);
        end
        put(0, 0, crc_ref(pl) & 16'h00FF);
        put(0, 1, crc_ref(pl) >> 8);
      end
      put_hdr({vc, 6'h01}, fnum, 1);
    end
  endtask

  task automatic finish_run();
    int budget;
    budget = exp_q.size() * 10 + 100;
    for (int c = 0; c < budget; c++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("stream_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("byte[%0d]", i), got_q[i], exp_q[i]);
    chk("err_len", err_len, exp_err);
    chk("frame_cnt", frame_cnt, fnum);
  endtask

  task automatic run(input int nfr, input int wc,
                     input logic [1:0] vc, input logic [5:0] dt,
                     input int ind, input int outd, input int mode);
    @(negedge clk);
    in_duty = ind;
    out_duty = outd;
    build(nfr, wc, vc, dt, mode);
    finish_run();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_q.delete();
    in_ptr = 0;
    got_q.delete();
    got_cyc.delete();
    fnum = 0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_tlast"}, m_tlast, 0);
    chk({tag, "_tuser"}, m_tuser, 0);
    chk({tag, "_err"}, err_len, 0);
    chk({tag, "_tready"}, s_tready, 0);
    chk({tag, "_fcnt"}, frame_cnt, 0);
  endtask

  // drive inputs just after the active edge
  always @(posedge clk) begin
    #1;
    m_tready = ($urandom_range(99) < out_duty);
    if (rst_n && in_ptr < in_q.size()) begin
      if (!(s_tvalid && !took))
        s_tvalid = ($urandom_range(99) < in_duty);
      {s_tuser, s_tlast, s_tdata} = in_q[in_ptr];
    end else begin
      s_tvalid = 1'b0;
    end
  end

  // sample mid-cycle: values here are what the next edge handshakes
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stall = 0;
      took = 0;
    end else begin
      if (stall)
        chk("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, held);
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tuser, m_tlast, m_tdata});
        got_cyc.push_back(cyc);
      end
      stall = m_tvalid && !m_tready;
      held = {m_tvalid, m_tuser, m_tlast, m_tdata};
      took = s_tvalid && s_tready;
      if (took) in_ptr++;
      if (s_tvalid && s_tuser && !tu_seen) begin
        tu_seen = 1;
        tu_cyc = cyc;
      end
    end
  end

  int flen;
  int wcr;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // basic frame, full throughput
    run(1, 4, 2'd0, 6'h2A, 100, 100, 0);
    chk("fs0", got_q[0], {2'b10, 8'h00});
    chk("fs1", got_q[1], {2'b00, 8'h01});
    chk("fs2", got_q[2], {2'b00, 8'h00});
    chk("fs3", got_q[3], {2'b01, 8'h1A});
    chk("lp0", got_q[4], {2'b10, 8'h2A});
    chk("lp1", got_q[5], {2'b00, 8'h04});
    chk("lp3", got_q[7], {2'b00, 8'h33});
    chk("fe0", got_q[44], {2'b10, 8'h01});
    chk("fe1", got_q[45], {2'b00, 8'h01});
    chk("fe3", got_q[47], {2'b01, 8'h1D});
    chk("no_bubble", got_cyc[got_cyc.size()-1] - got_cyc[0],
        got_cyc.size() - 1);
    chk("fs_latency", got_cyc[0] - tu_cyc, 1);

    // CRC vector
    run(1, 24, 2'd1, 6'h2A, 100, 100, 1);
    chk("crc_lo", got_q[32], {2'b00, 8'hF0});
    chk("crc_hi", got_q[33], {2'b01, 8'h00});

    // backpressure with random input gaps
    wcr = $urandom_range(1, 20);
    run(2, wcr, 2'($urandom_range(3)), 6'($urandom_range(63)),
        70, 50, 0);

    // three frames after reset: FS/FE carry 1, 2, 3
    do_reset();
    run(3, 3, 2'd2, 6'h2B, 100, 100, 0);
    flen = 4 + LPF * (4 + 3 + 2) + 4;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fs_wc%0d", k), got_q[k*flen+1], 10'(k + 1));
      chk($sformatf("fe_wc%0d", k), got_q[k*flen+flen-3],
          10'(k + 1));
    end

    // early tlast, then sticky across a clean frame
    run(1, 4, 2'd0, 6'h2A, 100, 100, 2);
    run(1, 5, 2'd0, 6'h2A, 80, 80, 0);
    do_reset();
    chk("err_cleared", err_len, 0);

    // stray tuser inside a frame
    run(1, 4, 2'd3, 6'h12, 100, 100, 3);
    do_reset();

    // reset while in PAYLOAD
    @(negedge clk);
    in_duty = 100;
    out_duty = 100;
    build(1, 8, 2'd0, 6'h2A, 0);
    for (int c = 0; c < 50 && !s_tready; c++) @(negedge clk);
    chk("reach_payload", s_tready, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    do_reset();
    run(1, 6, 2'd0, 6'h2A, 100, 100, 0);
    chk("post_rst_wc_lo", got_q[1], {2'b00, 8'h01});
    chk("post_rst_wc_hi", got_q[2], {2'b00, 8'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csi2_packet_builder.md
# csi2_packet_builder

Builds MIPI CSI-2 packets from a raw pixel byte stream: Frame Start short packet, one long packet per line (header + ECC, payload, CRC-16 footer), Frame End short packet after the last line. Sits directly upstream of `csi2_tx_dphy_stub` and drives its AXI-Stream byte input. Output is a registered byte stream with full backpressure.

## Interface
- `LINES_PER_FRAME`, 4: lines per frame; FE is emitted after this many long packets.
- `WC_W`, 16: width of the word-count field and counter.
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_vc` in 2: virtual channel; latched at frame start.
- `cfg_dt` in 6: long-packet data type, e.g. 0x2A for RAW8; latched at frame start.
- `cfg_wc` in WC_W: payload bytes per line, must be ≥1; latched at frame start.
- `s_axis_tdata` in 8: pixel byte.
- `s_axis_tvalid` in 1: pixel byte valid.
- `s_axis_tready` out 1: pixel byte accepted.
- `s_axis_tlast` in 1: last byte of a line; used only for checking.
- `s_axis_tuser` in 1: first byte of a frame.
- `m_axis_tdata` out 8: packet byte.
- `m_axis_tvalid` out 1: packet byte valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last byte of a packet.
- `m_axis_tuser` out 1: first byte of a packet.
- `err_len` out 1: sticky flag; input `tlast` did not match `cfg_wc`.
- `frame_cnt` out 16: current frame number.

## Operation
- **Packet header**: 4 bytes, sent as DI, WC[7:0], WC[15:8], ECC.
  - DI = {vc, dt}.
  - ECC is the CSI-2 v1.x 6-bit Hamming code over D[23:0] = {WC, DI}, with bits 7:6 = 0.
- **Short packets**:
  - FS: DT = 0x00, WC = frame number.
  - FE: DT = 0x01, WC = frame number.
- **Footer**: CRC-16, polynomial x^16+x^12+x^5+1, reflected form 0x8408, init 0xFFFF, no final XOR. It covers payload bytes only and is sent low byte first.
- **Frame number**:
  - Resets to 0.
  - Increments when FS is generated; 0xFFFF wraps to 1, never 0.
- **States**:
  - IDLE → FS_HDR when `s_axis_tvalid && s_axis_tuser`. The cfg inputs are latched here and the pixel byte is not consumed.
  - FS_HDR (4 bytes) → LP_HDR.
  - LP_HDR (4 bytes) → PAYLOAD.
  - PAYLOAD (cfg_wc bytes) → CRC.
  - CRC (2 bytes) → LP_HDR if line_cnt < LINES_PER_FRAME−1, else FE_HDR.
  - FE_HDR (4 bytes) → IDLE.
- **Byte counters**: each state's byte counter advances only when a byte is loaded into the output register.
- **Input ready**: `s_axis_tready = (state==PAYLOAD) && (!m_axis_tvalid || m_axis_tready)`. Payload bytes pass straight through to the output register.
- **tlast check**:
  - PAYLOAD ends on byte count = cfg_wc regardless of `tlast`.
  - `err_len` sets if `tlast` is high on any payload byte other than byte cfg_wc−1.
  - `err_len` also sets if `tlast` is low on byte cfg_wc−1.
  - `err_len` clears only on reset.
- **tuser inside a frame**: `s_axis_tuser` high on an accepted payload byte is ignored as data framing and sets `err_len`.
- **Output flags**:
  - `m_axis_tuser` = 1 on byte 0 of every header.
  - `m_axis_tlast` = 1 on the 2nd CRC byte and on the 4th byte of FS and FE.

## Timing
- **Reset values**:
  - State IDLE, `line_cnt` 0, `frame_cnt` 0.
  - `m_axis_tvalid` 0, `m_axis_tdata` 0x00, `m_axis_tlast` 0, `m_axis_tuser` 0.
  - `err_len` 0, `s_axis_tready` 0.
- **Output register**: one stage.
  - Loads when `!m_axis_tvalid || m_axis_tready`.
  - Holds data and flags stable while `m_axis_tvalid && !m_axis_tready`.
- **Latency**:
  - The first FS byte is valid 1 cycle after the tuser byte is seen in IDLE.
  - A payload byte appears on `m_axis_tdata` 1 cycle after its input handshake.
- **Throughput**: 1 byte/cycle with `m_axis_tready` tied high. There are no bubbles between packets if the input is always valid.
- **CRC timing**: CRC updates on each accepted payload byte. CRC low byte is emitted the cycle after the last payload byte is loaded.
- **Reset mid-packet**: all outputs return to reset values asynchronously and the partial packet is dropped. After reset, the next tuser byte starts a new frame numbered 1.

## Test plan
- **Basic frame**: LINES_PER_FRAME=1, vc=0, dt=0x2A, wc=4, tready high.
  - Output: 00 01 00 1A | 2A 04 00 33 | 4 payload bytes | CRC L H | 01 01 00 1D.
  - `tlast` is high on bytes 4, 14 and 18.
- **CRC vector**: wc=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → footer F0 00.
- **Backpressure**: random `m_axis_tready` at 50% duty → byte sequence identical to the `tready`-high run; no byte duplicated or dropped; data held stable while stalled.
- **Multi-line and frame number**: LINES_PER_FRAME=4, 3 frames → one FS, 4 long packets and one FE per frame; FS/FE WC = 1, 2, 3.
- **Length error**: wc=4 with input `tlast` on byte 2 → packet still carries 4 payload bytes; `err_len` = 1 and stays 1 until `rst_n` is low.
- **Reset mid-payload**: assert `rst_n` low during PAYLOAD → all outputs return to reset values immediately; the next frame emits FS with WC = 0x0001.
